// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC load enable, runs the req/ack handshake with
// instruction memory, buffers one instruction for Decode and squashes it on redirects.
module fetch_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IWIDTH  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  PCF,
  input  logic              BranchTakenE,
  input  logic              PCSrcW,
  input  logic              StallD,
  input  logic              imem_ack,
  input  logic [IWIDTH-1:0] imem_rdata,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  output logic              enablePCFlipFlop,
  output logic [IWIDTH-1:0] InstrF,
  output logic              InstrValidF,
  output logic              FetchError
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StBoot, StReq, StFull, StDrain, StError} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic                valid_q, err_q;
  logic                redirect, timed_out, waiting;

  always_comb begin
    redirect         = BranchTakenE | PCSrcW;
    timed_out        = (wait_cnt_q == CntLast) && !imem_ack;
    state_d          = state_q;
    addr_d           = addr_q;
    instr_d          = instr_q;
    imem_req         = 1'b0;
    imem_addr        = '0;
    enablePCFlipFlop = 1'b0;

    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        imem_req         = 1'b1;
        imem_addr        = PCF;
        addr_d           = PCF;
        enablePCFlipFlop = redirect | imem_ack;
        if (imem_ack) begin
          // Data accepted only when no redirect squashes it in the same cycle.
          if (!redirect) begin
            instr_d = imem_rdata;
            state_d = StFull;
          end
        end else if (timed_out) begin
          state_d = StError;
        end else if (redirect) begin
          state_d = StDrain;
        end
      end
      StFull: begin
        enablePCFlipFlop = redirect;
        if (redirect || !StallD) state_d = StReq;
      end
      StDrain: begin
        // Keep presenting the abandoned address until the memory retires it.
        imem_req         = 1'b1;
        imem_addr        = addr_q;
        enablePCFlipFlop = redirect;
        if (imem_ack)       state_d = StReq;
        else if (timed_out) state_d = StError;
      end
      StError: ;
      default: state_d = StBoot;
    endcase

    waiting    = (state_q == StReq) || (state_q == StDrain);
    wait_cnt_d = (waiting && (state_d == state_q) && !imem_ack) ? wait_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StBoot;
      addr_q     <= '0;
      wait_cnt_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      valid_q    <= (state_d == StFull);
      err_q      <= (state_d == StError);
    end
  end

  assign InstrF      = instr_q;
  assign InstrValidF = valid_q;
  assign FetchError  = err_q;

endmodule
